// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter one byte at a time through a
// write-strobe / wait_retrieve handshake, with sticky overflow reporting.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          enable,
    input  logic          clr_overflow,
    input  logic          uart_wait_retrieve,
    input  logic          uart_send_busy,
    output logic [7:0]    uart_data,
    output logic          uart_write_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          idle
);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_WAIT_ACCEPT = 2'd2,
        ST_WAIT_DRAIN  = 2'd3
    } state_t;

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    state_t      r_state;
    logic        r_overflow;
    logic        r_write_data;
    logic [7:0]  r_data;

    logic [AW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_start;

    // Occupancy flags and the push/pop/launch qualifiers; flush overrides both pointers' updates.
    always_comb begin
        w_count   = r_wr_ptr - r_rd_ptr;
        w_full    = (w_count == CNT_FULL);
        w_empty   = (w_count == CNT_ZERO);
        w_pop     = (r_state == ST_ISSUE) & ~w_empty & ~flush;
        w_push    = wr_en & (~w_full | w_pop) & ~flush;
        w_ovf_set = wr_en & w_full & ~w_pop & ~flush;
        w_start   = enable & ~w_empty & ~flush & ~uart_wait_retrieve & ~uart_send_busy;
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointers, one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= CNT_ZERO;
            r_rd_ptr <= CNT_ZERO;
        end else begin
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
        end
    end

    // Sticky overflow; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // UART handshake sequencer; the head byte is captured on entry to ISSUE so it is stable for the pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_write_data <= 1'b0;
            r_data       <= 8'h00;
        end else begin
            r_write_data <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_ISSUE;
                        r_write_data <= 1'b1;
                        r_data       <= r_mem[r_rd_ptr[AW-1:0]];
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_ACCEPT;
                end
                ST_WAIT_ACCEPT: begin
                    if (uart_wait_retrieve) begin
                        r_state <= ST_WAIT_DRAIN;
                    end
                end
                ST_WAIT_DRAIN: begin
                    if (!uart_wait_retrieve && !uart_send_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_data       = r_data;
    assign uart_write_data = r_write_data;
    assign full            = w_full;
    assign empty           = w_empty;
    assign count           = w_count;
    assign overflow        = r_overflow;
    assign idle            = w_empty & (r_state == ST_IDLE);

endmodule
